// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared definitions for the multi-cycle shift sequencer:
//   - state_e   : sequencer FSM states (S_IDLE / S_SHIFT / S_DONE)
//   - DIR_LEFT / DIR_RIGHT : shift direction encodings
//   - WIDTH_DEF / CNT_W_DEF : default operand width and shift-count width
//   - right_fill(): fill bit for a right step (sign or zero)
// Optional feature macro: ARITH_SHIFT_EN (arithmetic right shifts).
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Fill bit entering the MSB on a right step: replicate the sign only for
  // arithmetic shifts, otherwise shift in zero.
  function automatic logic right_fill(input logic arith, input logic msb);
    return arith & msb;
  endfunction

endpackage : shift_ctrl_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-position shifter used on the accumulator
// feedback path of shift_sequencer.
// Ports:
//   operand  in  WIDTH  value to shift
//   dir      in  1      DIR_LEFT / DIR_RIGHT
//   fill     in  1      bit entering the MSB on a right step
//   shifted  out WIDTH  operand shifted by one position
// Optional feature macro: ARITH_SHIFT_EN (affects only the fill source in the
// parent; this module is identical in both builds).
// -----------------------------------------------------------------------------
module shift_step
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] operand,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  // One-position left or right shift of the operand.
  always_comb begin
    shifted = operand;
    if (dir == DIR_LEFT) begin
      shifted = {operand[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {fill, operand[WIDTH-1:1]};
    end
  end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Turns a single-position shift step into a 0..(2**CNT_W-1) position shift by
// applying one step per clock to an accumulator.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_valid/start_ready  request handshake (accepted only in S_IDLE)
//   data_in, shift_dir, shift_amt [, shift_arith]  request payload
//   result/result_valid/result_ready  result handshake (held in S_DONE)
//   busy                     high in S_SHIFT or S_DONE
// Optional feature macro: ARITH_SHIFT_EN adds shift_arith; a right shift with
// shift_arith=1 replicates the sign bit on every step.
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_dir,
  input  logic [CNT_W-1:0] shift_amt,
`ifdef ARITH_SHIFT_EN
  input  logic             shift_arith,
`endif
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             dir_q,   dir_d;
  logic             arith_q, arith_d;
  logic             fill_s;
  logic [WIDTH-1:0] step_s;

`ifdef ARITH_SHIFT_EN
  logic arith_in_s;
  assign arith_in_s = shift_arith;
`else
  logic arith_in_s;
  assign arith_in_s = 1'b0;
`endif

  assign fill_s = right_fill(arith_q, acc_q[WIDTH-1]);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .operand (acc_q),
    .dir     (dir_q),
    .fill    (fill_s),
    .shifted (step_s)
  );

  // Outputs decode straight from registered state; rst masks start_ready so a
  // request is never advertised as acceptable while reset is asserted.
  assign start_ready  = (state_q == S_IDLE) && !rst;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result       = acc_q;

  // Next-state, accumulator and down-counter logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          acc_d   = data_in;
          rem_d   = shift_amt;
          dir_d   = shift_dir;
          arith_d = arith_in_s;
          if (shift_amt == CNT_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        acc_d = step_s;
        rem_d = rem_q - CNT_ONE;
        // The step taken with rem==1 is the last one.
        if (rem_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= {WIDTH{1'b0}};
      rem_q   <= CNT_ZERO;
      dir_q   <= DIR_LEFT;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

endmodule : shift_sequencer
